// File: rtl/sar_search.sv
// Successive-approximation search: drives trial into a 16-bit comparator, recovers target MSB-first.
// Latency: k+1 cycles from accepted start to done (k = TEST cycles, 1..16; worst case 17).
// Backpressure: none; start is sampled only in IDLE and ignored while busy or done.
module sar_search (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic        gt,
    input  logic        lt,
    input  logic        eq,
    output logic [15:0] trial,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        exact,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  idx;
    logic        onehot;
    logic        last;
    logic [15:0] bit_cur;
    logic [15:0] bit_nxt;

    // Flag sanity and bit masks for the bit currently under test and the one below it
    always_comb begin
        onehot  = (gt ^ lt ^ eq) & ~(gt & lt & eq);
        last    = (idx == 4'd0);
        bit_cur = 16'h0001 << idx;
        bit_nxt = 16'h0001 << (idx - 4'd1);
    end

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a search ends on bad flags, a match, or after the LSB is resolved
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = TEST;
            TEST:    if (!onehot || eq || last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state only, so no input reaches an output combinationally
    always_comb begin
        busy = (state == TEST);
        done = (state == DONE);
    end

    // Trial/index datapath and held result flags; pure bit set/clear so trial never wraps
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            trial  <= 16'h0000;
            idx    <= 4'd0;
            result <= 16'h0000;
            exact  <= 1'b0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        trial  <= 16'h8000;
                        idx    <= 4'd15;
                        result <= 16'h0000;
                        exact  <= 1'b0;
                        err    <= 1'b0;
                    end
                end
                TEST: begin
                    if (!onehot) begin
                        err    <= 1'b1;
                        result <= trial;
                    end else if (eq) begin
                        exact  <= 1'b1;
                        result <= trial;
                    end else if (last) begin
                        // Target below the final trial means bit 0 must be zero
                        result <= lt ? (trial & ~16'h0001) : trial;
                    end else if (lt) begin
                        trial <= (trial & ~bit_cur) | bit_nxt;
                        idx   <= idx - 4'd1;
                    end else begin
                        trial <= trial | bit_nxt;
                        idx   <= idx - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sar_search.sv
// Scoreboard bench for sar_search: a behavioural comparator closes the loop around the DUT.
// Stimulus pushes expected result/flags/TEST-cycle count; a negedge monitor checks on every done.
// Also covers reset values, mid-search reset, start during TEST and back-to-back searches.
module tb_sar_search;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        gt;
    logic        lt;
    logic        eq;
    logic [15:0] trial;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        exact;
    logic        err;

    logic [15:0] target;
    logic        fault;

    int checks;
    int failures;

    typedef struct {
        logic [15:0] res;
        logic        exact;
        logic        err;
        int          k;
        bit          seq;
    } exp_t;

    exp_t q[$];
    int   cnt;

    sar_search dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .start  (start),
        .gt     (gt),
        .lt     (lt),
        .eq     (eq),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .exact  (exact),
        .err    (err)
    );

    // Combinational comparator model; fault forces both gt and lt high
    assign gt = fault ? 1'b1 : (target > trial);
    assign lt = fault ? 1'b1 : (target < trial);
    assign eq = fault ? 1'b0 : (target == trial);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] res, input logic ex, input logic er, input int k, input bit seq);
        exp_t e;
        e.res = res; e.exact = ex; e.err = er; e.k = k; e.seq = seq;
        q.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        #1;
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s timeout pending=%0d required=0", name, q.size());
            q.delete();
        end
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_trial"},  {16'h0, trial},  32'h0);
        chk({tag, "_busy"},   {31'h0, busy},   32'h0);
        chk({tag, "_done"},   {31'h0, done},   32'h0);
        chk({tag, "_result"}, {16'h0, result}, 32'h0);
        chk({tag, "_exact"},  {31'h0, exact},  32'h0);
        chk({tag, "_err"},    {31'h0, err},    32'h0);
    endtask

    // Monitor: counts TEST cycles, checks trial walk when asked, scores each done pulse
    always @(negedge clk) begin
        logic [15:0] exp_trial;
        exp_t        e;
        if (!n_rst) begin
            cnt = 0;
        end else begin
            if (busy) begin
                cnt++;
                if (q.size() > 0 && q[0].seq) begin
                    exp_trial = 16'h8000 >> (cnt - 1);
                    chk("trial_seq", {16'h0, trial}, {16'h0, exp_trial});
                end
            end
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("result", {16'h0, result}, {16'h0, e.res});
                    chk("exact",  {31'h0, exact},  {31'h0, e.exact});
                    chk("err",    {31'h0, err},    {31'h0, e.err});
                    chk("test_cycles", cnt, e.k);
                end
                cnt = 0;
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        cnt      = 0;
        start    = 1'b0;
        fault    = 1'b0;
        target   = 16'h0000;
        n_rst    = 1'b0;
        #1;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;

        // MSB-only target matches on the very first trial
        target = 16'h8000;
        push(16'h8000, 1'b1, 1'b0, 1, 1'b0);
        pulse_start();
        wait_drain("t8000");

        // Zero never matches; trial walks 8000..0001 over all 16 cycles
        target = 16'h0000;
        push(16'h0000, 1'b0, 1'b0, 16, 1'b1);
        pulse_start();
        wait_drain("t0000");

        // All-ones: match on the last trial
        target = 16'hFFFF;
        push(16'hFFFF, 1'b1, 1'b0, 16, 1'b0);
        pulse_start();
        wait_drain("tffff");

        // Lowest set bit 2, so the match lands on TEST cycle 14
        target = 16'h1234;
        push(16'h1234, 1'b1, 1'b0, 14, 1'b0);
        pulse_start();
        wait_drain("t1234");

        // Bad flags on TEST cycle 3: trial has gone 8000 -> 4000 -> 2000 after two lt steps
        target = 16'h00FF;
        push(16'h2000, 1'b0, 1'b1, 3, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 fault = 1'b1;
        @(posedge clk);
        #1 fault = 1'b0;
        wait_drain("fault");

        // Start pulsed in the middle of a search must not disturb it or queue another
        target = 16'h00A0;
        push(16'h00A0, 1'b1, 1'b0, 11, 1'b0);
        pulse_start();
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain("start_in_test");
        repeat (4) @(posedge clk);
        #1 chk("no_restart", {31'h0, busy}, 32'h0);

        // Reset at TEST cycle 7: outputs clear at once and no done may follow
        target = 16'h0001;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        chk_reset_vals("midrst");
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("midrst_idle", {31'h0, busy}, 32'h0);

        // Start held high: two searches separated by exactly one idle cycle
        target = 16'h4000;
        push(16'h4000, 1'b1, 1'b0, 2, 1'b0);
        push(16'h4000, 1'b1, 1'b0, 2, 1'b0);
        @(posedge clk);
        #1 start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("b2b_first_done", {31'h0, done}, 32'h1);
        @(negedge clk);
        chk("b2b_gap_idle", {31'h0, busy}, 32'h0);
        @(negedge clk);
        chk("b2b_gap_busy", {31'h0, busy}, 32'h1);
        #1 start = 1'b0;
        wait_drain("b2b");
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
